// File: rtl/tdm_demux.sv
// Serial TDM receiver: frames of NCH words of W bits (MSB first), marked by fsync on
// the first bit, are staged and then published to ch_data atomically with a one-cycle strobe.
module tdm_demux #(
    parameter int NCH = 4,
    parameter int W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fsync,
    input  logic             sdata,
    output logic [NCH*W-1:0] ch_data,
    output logic             frame_valid,
    output logic             sync_err,
    output logic             in_frame
);

    localparam int BW = (W > 1) ? $clog2(W) : 1;
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic [W-2:0]     shift_r;
    logic [BW-1:0]    bit_cnt_r;
    logic [CW-1:0]    chan_r;
    logic [NCH*W-1:0] staging_r;
    logic [NCH*W-1:0] staging_nx_s;
    logic [NCH*W-1:0] ch_data_r;
    logic             frame_valid_r;
    logic             sync_err_r;
    logic             in_frame_s;
    logic [W-1:0]     word_s;
    logic [W-2:0]     shift_nx_s;
    logic [W-2:0]     shift_start_s;
    logic             word_end_s;
    logic             frame_end_s;

    assign word_s        = {shift_r, sdata};
    assign shift_nx_s    = word_s[W-2:0];
    assign shift_start_s = (W-1)'(sdata);
    assign word_end_s    = (bit_cnt_r == BW'(W-1));
    assign frame_end_s   = word_end_s && (chan_r == CW'(NCH-1));

    // Staging contents with the word completing this cycle dropped into its slot.
    always_comb begin
        staging_nx_s = staging_r;
        staging_nx_s[int'(chan_r)*W +: W] = word_s;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic: a frame's last bit drops to IDLE; any fsync seen in SHIFT resyncs.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fsync) begin
                    state_nx_s = ST_SHIFT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (fsync) begin
                    state_nx_s = ST_SHIFT;
                end else if (frame_end_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_SHIFT;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Output logic: the gap cycle after a published frame still counts as in-frame
    // when fsync immediately restarts, so back-to-back frames show no dropout.
    always_comb begin
        in_frame_s = 1'b0;
        case (state_r)
            ST_SHIFT: in_frame_s = 1'b1;
            ST_IDLE:  in_frame_s = frame_valid_r && fsync;
            default:  in_frame_s = 1'b0;
        endcase
    end

    // Datapath: shifting, word staging, frame publication and error strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r       <= '0;
            bit_cnt_r     <= '0;
            chan_r        <= '0;
            staging_r     <= '0;
            ch_data_r     <= '0;
            frame_valid_r <= 1'b0;
            sync_err_r    <= 1'b0;
        end else begin
            frame_valid_r <= 1'b0;
            sync_err_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (fsync) begin
                        shift_r   <= shift_start_s;
                        bit_cnt_r <= BW'(1);
                        chan_r    <= '0;
                        staging_r <= '0;
                    end else begin
                        shift_r   <= shift_r;
                    end
                end
                ST_SHIFT: begin
                    if (fsync) begin
                        // Mid-frame sync: drop the partial frame, restart on this bit.
                        shift_r    <= shift_start_s;
                        bit_cnt_r  <= BW'(1);
                        chan_r     <= '0;
                        staging_r  <= '0;
                        sync_err_r <= 1'b1;
                    end else if (word_end_s) begin
                        shift_r   <= shift_nx_s;
                        staging_r <= staging_nx_s;
                        bit_cnt_r <= '0;
                        if (frame_end_s) begin
                            chan_r        <= '0;
                            ch_data_r     <= staging_nx_s;
                            frame_valid_r <= 1'b1;
                        end else begin
                            chan_r <= chan_r + CW'(1);
                        end
                    end else begin
                        shift_r   <= shift_nx_s;
                        bit_cnt_r <= bit_cnt_r + BW'(1);
                    end
                end
                default: begin
                    bit_cnt_r <= '0;
                    chan_r    <= '0;
                end
            endcase
        end
    end

    assign ch_data     = ch_data_r;
    assign frame_valid = frame_valid_r;
    assign sync_err    = sync_err_r;
    assign in_frame    = in_frame_s;

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Time-division demultiplexer that undoes the select-based multiplexing used by the team's mux primitives.
- Receives a 1-bit serial stream framed by a frame-sync pulse and distributes consecutive W-bit words into NCH parallel channel registers.
- Publishes a complete frame atomically with a one-cycle valid strobe and flags framing errors.
- Sits at the receive end of the team's TDM serial link, feeding per-channel logic.

Parameters:
- NCH, 4, number of channels per frame (>=2).
- W, 8, bits per channel word, MSB first (>=2).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- fsync  input  1  frame sync; high in the cycle carrying bit W-1 of channel 0.
- sdata  input  1  serial data, one bit per cycle.
- ch_data  output  NCH*W  last complete frame; channel k at bits [k*W +: W].
- frame_valid  output  1  one-cycle pulse when ch_data is updated.
- sync_err  output  1  one-cycle pulse when fsync arrives mid-frame.
- in_frame  output  1  high while in SHIFT state.

Behaviour:
- Reset (async, rst_n=0) drives the block to this state; it holds until rst_n rises and the next edge:
  - ch_data=0, frame_valid=0, sync_err=0, in_frame=0.
  - State IDLE; bit counter, channel counter and staging register all 0.
- FSM has two states, IDLE and SHIFT.
- IDLE:
  - fsync=0: stay in IDLE; sdata is ignored.
  - fsync=1: capture sdata as bit W-1 of ch0 in the shift register, set bit_cnt=1 and chan=0, go to SHIFT.
- SHIFT, each cycle:
  - Shift sdata into the W-bit shift register, MSB first, and increment bit_cnt.
  - When bit_cnt==W-1, write the completed word {shift, sdata} to staging slot chan, reset bit_cnt to 0, and increment chan.
  - When chan==NCH-1 and bit_cnt==W-1 (last bit of the frame): copy the full staging contents, including the final word, to ch_data. frame_valid is high in the next cycle only.
- Latency: fsync at cycle t0 gives ch_data and frame_valid valid at cycle t0+NCH*W (W=8, NCH=4: t0+32).
- Frame boundary:
  - In the cycle after a frame's last bit, fsync=1 starts the next frame immediately (back-to-back, no gap) and in_frame stays 1.
  - fsync=0 in that cycle returns the block to IDLE with no error.
- Mid-frame fsync (fsync=1 in SHIFT at any bit other than the first bit of a new frame):
  - Discard the staging contents; ch_data is unchanged.
  - sync_err pulses for one cycle, the next cycle.
  - The current sdata is treated as bit W-1 of ch0 of a new frame, with bit_cnt=1 and chan=0.
- fsync on the last bit of a frame counts as mid-frame: that frame is aborted, not published, and sync_err pulses.
- frame_valid and sync_err are never high in the same cycle.
- ch_data holds its value between frames.
- Reset asserted mid-frame: partial data is lost; ch_data returns to 0.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately. Release rst_n with fsync=0 for 10 cycles -> in_frame=0, no pulses.
- Single frame: fsync at t0, words 0xA5, 0x3C, 0xFF, 0x01 (MSB first) -> at t0+32, ch_data=0x01FF3CA5 and frame_valid=1 for exactly one cycle; in_frame=0 at t0+32.
- Back-to-back: second fsync at t0+32 with words 0x11, 0x22, 0x33, 0x44 -> 0x01FF3CA5 at t0+32, then 0x44332211 at t0+64, in_frame continuously 1, no sync_err.
- Mid-frame resync: fsync at t0, a second fsync at t0+13, then a clean frame 0xDE, 0xAD, 0xBE, 0xEF -> sync_err=1 at t0+14 only, ch_data unchanged until t0+45, then 0xEFBEADDE with frame_valid.
- Late abort: fsync on the frame's last bit (t0+31) -> no frame_valid, sync_err at t0+32, new frame starting at t0+31 publishes at t0+63.
- Reset mid-frame: rst_n low at t0+20 for 2 cycles, then a fresh frame -> ch_data=0 during reset, only the fresh frame is published.
